// File: rtl/scaler_ddr_write_packer_if.sv
// rtl/scaler_ddr_write_packer_if.sv - packed-word write bus between the packer and the DDR write master
interface scaler_ddr_write_packer_if;
    logic [63:0] WDATA_O;
    logic        WVALID_O;
    logic        WREADY_I;
    logic        WSOF_O;
    logic        WEOL_O;
    logic        WEOF_O;

    modport master (
        output WDATA_O,
        output WVALID_O,
        input  WREADY_I,
        output WSOF_O,
        output WEOL_O,
        output WEOF_O
    );

    modport slave (
        input  WDATA_O,
        input  WVALID_O,
        output WREADY_I,
        input  WSOF_O,
        input  WEOL_O,
        input  WEOF_O
    );
endinterface

// File: rtl/scaler_ddr_write_packer.sv
// rtl/scaler_ddr_write_packer.sv - packs scaled RGB888 pixels two per 64-bit word with frame flags into a FWFT FIFO
module scaler_ddr_write_packer #(
    parameter int G_DATA_WIDTH  = 8,
    parameter int G_FIFO_AWIDTH = 2
) (
    input  logic                    VIDEO_CLK_I,
    input  logic                    RESET_I,
    input  logic [12:0]             HORZ_RES_I,
    input  logic [12:0]             VERT_RES_I,
    input  logic                    DATA_VALID_I,
    input  logic [G_DATA_WIDTH-1:0] DATA_R_I,
    input  logic [G_DATA_WIDTH-1:0] DATA_G_I,
    input  logic [G_DATA_WIDTH-1:0] DATA_B_I,
    scaler_ddr_write_packer_if.master wbus,
    output logic                    FRAME_DONE_O,
    output logic                    OVERFLOW_O,
    output logic                    BUSY_O
);

    localparam int DEPTH = 1 << G_FIFO_AWIDTH;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t      state_q, state_d;
    logic [12:0] h_res_q, v_res_q;
    logic [12:0] pix_cnt_q, line_cnt_q;
    logic [12:0] eff_h, eff_v, cur_x, cur_y;
    logic        res_ok, pix_accept, last_pix, last_line, frame_last;
    logic [23:0] pix_rgb, half_q;
    logic [23:0] word_lo, word_hi;
    logic        push;
    logic [66:0] push_word;

    logic [66:0]            mem [DEPTH];
    logic [G_FIFO_AWIDTH:0] wr_ptr_q, rd_ptr_q;
    logic                   fifo_empty, fifo_full, pop, wr_en;
    logic [66:0]            head;
    logic                   frame_done_q, overflow_q;

    assign pix_rgb = {DATA_R_I, DATA_G_I, DATA_B_I};

    // Position of the incoming pixel; in IDLE the pixel is (0,0) against the live resolution inputs.
    always_comb begin
        res_ok = (HORZ_RES_I != 13'd0) && (VERT_RES_I != 13'd0);
        if (state_q == S_IDLE) begin
            eff_h = HORZ_RES_I;
            eff_v = VERT_RES_I;
            cur_x = 13'd0;
            cur_y = 13'd0;
        end else begin
            eff_h = h_res_q;
            eff_v = v_res_q;
            cur_x = pix_cnt_q;
            cur_y = line_cnt_q;
        end
        pix_accept = DATA_VALID_I && ((state_q == S_ACTIVE) || res_ok);
        last_pix   = (cur_x == eff_h - 13'd1);
        last_line  = (cur_y == eff_v - 13'd1);
        frame_last = last_pix && last_line;
    end

    // FSM state register.
    always_ff @(posedge VIDEO_CLK_I) begin
        if (RESET_I) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // FSM next state: enter ACTIVE on the first accepted pixel, leave after the frame's last pixel.
    always_comb begin
        state_d = state_q;
        if (pix_accept) begin
            if (frame_last) state_d = S_IDLE;
            else            state_d = S_ACTIVE;
        end
    end

    // FSM outputs.
    always_comb begin
        BUSY_O = (state_q == S_ACTIVE);
    end

    // Pixel/line counters and the resolution latched at the start of each frame.
    always_ff @(posedge VIDEO_CLK_I) begin
        if (RESET_I) begin
            h_res_q    <= 13'd0;
            v_res_q    <= 13'd0;
            pix_cnt_q  <= 13'd0;
            line_cnt_q <= 13'd0;
        end else if (pix_accept) begin
            if (state_q == S_IDLE) begin
                h_res_q <= HORZ_RES_I;
                v_res_q <= VERT_RES_I;
            end
            if (last_pix) begin
                pix_cnt_q  <= 13'd0;
                line_cnt_q <= last_line ? 13'd0 : cur_y + 13'd1;
            end else begin
                pix_cnt_q  <= cur_x + 13'd1;
                line_cnt_q <= cur_y;
            end
        end
    end

    // Even-indexed pixels wait here for their odd partner.
    always_ff @(posedge VIDEO_CLK_I) begin
        if (RESET_I)                       half_q <= 24'd0;
        else if (pix_accept && !cur_x[0])  half_q <= pix_rgb;
    end

    // Word assembly: odd pixel closes the pair, a lone even pixel at end of line is sent with an empty upper half.
    always_comb begin
        push      = pix_accept && (cur_x[0] || last_pix);
        word_lo   = cur_x[0] ? half_q : pix_rgb;
        word_hi   = cur_x[0] ? pix_rgb : 24'd0;
        push_word = {frame_last, last_pix, (cur_y == 13'd0) && (cur_x[12:1] == 12'd0),
                     8'h00, word_hi, 8'h00, word_lo};
    end

    // FIFO status; a push into a full FIFO survives only if a pop frees a slot in the same cycle.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[G_FIFO_AWIDTH] != rd_ptr_q[G_FIFO_AWIDTH]) &&
                     (wr_ptr_q[G_FIFO_AWIDTH-1:0] == rd_ptr_q[G_FIFO_AWIDTH-1:0]);
        pop        = !fifo_empty && wbus.WREADY_I;
        wr_en      = push && (!fifo_full || pop);
        head       = mem[rd_ptr_q[G_FIFO_AWIDTH-1:0]];
    end

    // FIFO storage; contents need no reset because the pointers qualify them.
    always_ff @(posedge VIDEO_CLK_I) begin
        if (wr_en) mem[wr_ptr_q[G_FIFO_AWIDTH-1:0]] <= push_word;
    end

    // FIFO pointers.
    always_ff @(posedge VIDEO_CLK_I) begin
        if (RESET_I) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Sticky overflow and the frame-complete pulse one cycle after the last pixel.
    always_ff @(posedge VIDEO_CLK_I) begin
        if (RESET_I) begin
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (push && !wr_en) overflow_q <= 1'b1;
            frame_done_q <= pix_accept && frame_last;
        end
    end

    // Head of FIFO drives the bus; everything reads zero while empty.
    always_comb begin
        wbus.WVALID_O = !fifo_empty;
        wbus.WDATA_O  = fifo_empty ? 64'd0 : head[63:0];
        wbus.WSOF_O   = !fifo_empty && head[64];
        wbus.WEOL_O   = !fifo_empty && head[65];
        wbus.WEOF_O   = !fifo_empty && head[66];
        FRAME_DONE_O  = frame_done_q;
        OVERFLOW_O    = overflow_q;
    end

endmodule

// File: doc/scaler_ddr_write_packer.md
Name: scaler_ddr_write_packer

Overview:
- Sits directly downstream of the image scaler output port, in the scaler's output video clock domain.
- Consumes the unstallable scaled RGB888 stream (valid-qualified, no frame markers).
- Tracks pixel and line position from the configured output resolution.
- Packs two pixels per 64-bit word with start-of-frame, end-of-line and end-of-frame side-band flags. Buffers the words in a small FIFO for the DDR write master, which can apply backpressure.

Parameters:
- G_DATA_WIDTH, 8, bits per colour component (fixed at 8).
- G_FIFO_AWIDTH, 2, log2 of FIFO depth (default depth 4 words).

Ports:
- VIDEO_CLK_I  in  1  single clock; the scaler output video clock.
- RESET_I  in  1  reset, synchronous, active-high.
- HORZ_RES_I  in  13  output image width in pixels; legal range 1..4095.
- VERT_RES_I  in  13  output image height in lines; legal range 1..4095.
- DATA_VALID_I  in  1  pixel valid from the scaler.
- DATA_R_I  in  8  red component.
- DATA_G_I  in  8  green component.
- DATA_B_I  in  8  blue component.
- WDATA_O  out  64  packed word: [31:0]={8'h00,R,G,B} of the even pixel; [63:32] the same layout for the odd pixel.
- WVALID_O  out  1  FIFO not empty; word and flags valid.
- WREADY_I  in  1  consumer accepts the word when WVALID_O and WREADY_I are both high.
- WSOF_O  out  1  word holds pixel (0,0).
- WEOL_O  out  1  last word of a line.
- WEOF_O  out  1  last word of the frame.
- FRAME_DONE_O  out  1  one-cycle pulse when the last pixel of a frame is accepted.
- OVERFLOW_O  out  1  sticky: a word was dropped because the FIFO was full.
- BUSY_O  out  1  FSM is in ACTIVE.

Behaviour:
Reset:
- On RESET_I=1 at a clock edge: FSM to IDLE; pixel counter, line counter, half-word register and FIFO pointers cleared.
- All outputs 0: WDATA_O=0, WVALID_O=0, flags 0, FRAME_DONE_O=0, OVERFLOW_O=0, BUSY_O=0.
- Reset mid-frame discards the partial word and all buffered words. No flags are emitted for the aborted frame.

FSM:
- IDLE: on DATA_VALID_I=1, if HORZ_RES_I!=0 and VERT_RES_I!=0, latch both resolutions, process this pixel as (0,0) and go to ACTIVE. If either resolution is 0, drop the pixel and stay in IDLE.
- ACTIVE: each valid pixel advances the pixel counter. When pixel counter = h_res-1, wrap it to 0 and increment the line counter. At pixel (h_res-1, v_res-1), pulse FRAME_DONE_O on the next cycle and return to IDLE.
- Resolution inputs are ignored while in ACTIVE; a change takes effect at the next frame.

Packing:
- An even pixel index is stored in the half register.
- An odd pixel index completes the word, which is pushed to the FIFO.
- If a line's last pixel has an even index (odd h_res), the word is pushed immediately with [63:32]=0.
- A line never shares a word with the next line.

Flags (stored in the FIFO alongside the data):
- WSOF = word contains pixel 0 of line 0.
- WEOL = word contains the line's last pixel.
- WEOF = WEOL and last line.

FIFO:
- First-word-fall-through, 67 bits wide, depth 2^G_FIFO_AWIDTH.
- Push happens on the cycle after the completing pixel is sampled, so WVALID_O rises 1 cycle after that pixel's DATA_VALID_I cycle when the FIFO was empty.
- Pop when WVALID_O and WREADY_I are both high.
- Full, push and pop in the same cycle: both proceed and the word is kept.
- Full, push without pop: the word is dropped, OVERFLOW_O is set and stays set until reset, and counters keep advancing so frame alignment is preserved.
- Empty, pop attempt: ignored.
- WDATA_O and the flags are held stable while WVALID_O=1 and WREADY_I=0.

Test Plan:
- h_res=4, v_res=2, 8 consecutive valid pixels, WREADY_I=1 -> 4 words. Word0 WSOF=1. Words 1 and 3 WEOL=1. Word3 WEOF=1. FRAME_DONE_O pulses once. WVALID_O first rises 1 cycle after pixel 1.
- h_res=3, v_res=2, pixel B values 1..6 -> words {0,2|1},{0,0|3},{0,5|4},{0,0|6}, with the second and fourth words WEOL=1 and the fourth word WEOF=1.
- h_res=16, v_res=1, WREADY_I=0 throughout -> 4 words held stable in the FIFO, remaining words dropped, OVERFLOW_O=1. Later words after WREADY_I=1 still carry the correct WEOL/WEOF on the final word.
- FIFO full with simultaneous push and pop (WREADY_I=1 on the push cycle) -> no drop, OVERFLOW_O stays 0, word order preserved.
- Reset asserted after 5 pixels of a 4x2 frame, then a new frame sent -> no stale words after reset. The first new word has WSOF=1 and all counters restart at 0.
- HORZ_RES_I changed from 4 to 2 during ACTIVE -> the current frame uses 4. The next frame uses 2 (WEOL on every word). HORZ_RES_I=0 in IDLE -> pixels dropped, BUSY_O stays 0.
